pipe_adder: RTL and testbench
=============================

PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 64, operand and result width in bits.
REQ-002 Parameter STAGES, default 4, number of pipeline stages; each stage adds one SLICE = WIDTH/STAGES bit slice.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operation presented on a, b, sub.
REQ-006 in_ready  output  1  block accepts the operation this cycle.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 sub  input  1  0 = a+b; 1 = a-b.
REQ-010 out_valid  output  1  result on sum/flags is valid.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 flags  output  4  {N, Z, C, V}, ARM semantics.

Function
REQ-014 The operation SHALL compute a + (sub ? ~b : b) + sub, i.e. two's-complement subtract via inverted b and carry-in 1.
REQ-015 Stage k (0..STAGES-1) SHALL add bits [k*SLICE +: SLICE] using the registered carry from stage k-1 (stage 0: carry-in = sub); lower sum slices and upper operand slices SHALL travel with the operation in pipeline registers.
REQ-016 The pipeline SHALL advance when adv = !out_valid || out_ready; in_ready SHALL equal adv combinationally.
REQ-017 An operation is accepted when in_valid && in_ready; it SHALL appear on out_valid exactly STAGES cycles later if adv stays high throughout.
REQ-018 When adv is low, every stage register, including the valid bits, SHALL hold; no operation is lost or duplicated, and order is preserved.
REQ-019 Throughput SHALL be one operation per cycle with out_ready held high.
REQ-020 Bubbles (in_valid low while accepting) SHALL propagate as invalid stages; sum/flags are don't-care when out_valid = 0.
REQ-021 N = sum[WIDTH-1]; Z = (sum == 0); C = carry out of bit WIDTH-1 (for subtract, C = 1 means no borrow).
REQ-022 V = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]), where b_eff is b after conditional inversion.
REQ-023 Flags SHALL be computed in the last stage and registered together with sum.
REQ-024 STAGES = 1 SHALL be legal and give a single-cycle registered adder.
REQ-025 WIDTH not divisible by STAGES, or STAGES < 1, SHALL be an elaboration-time error.

Reset
REQ-026 When reset is high at a rising edge, all stage valid bits, out_valid, sum and flags SHALL clear to 0 on that edge.
REQ-027 Operations in flight at reset SHALL be discarded; in_ready SHALL read 1 in the cycle after reset deasserts.
REQ-028 An operation offered in a reset cycle SHALL NOT be accepted.

Structure
REQ-029 Package pipe_adder_pkg SHALL hold the flags_t packed struct {n, z, c, v} and the flag-index constants.
REQ-030 Sub-module adder_slice, a combinational SLICE-bit adder (a, b, cin -> sum, cout, msb carry-in for V), SHALL be instantiated once per stage.
REQ-031 The stage registers SHALL be generated by a loop over STAGES; there is no other hierarchy.

Verification (WIDTH=64, STAGES=4)
REQ-032 5 + 3, out_ready=1 -> out_valid rises after exactly 4 cycles, sum=8, flags=0000.
REQ-033 0xFFFF_FFFF_FFFF_FFFF + 1 -> sum=0, Z=1, C=1, N=0, V=0, with the carry crossing all four slices.
REQ-034 sub: 3 - 5 -> sum=0xFFFF_FFFF_FFFF_FFFE, N=1, C=0; 5 - 5 -> sum=0, Z=1, C=1.
REQ-035 0x7FFF_FFFF_FFFF_FFFF + 1 -> sum=0x8000_0000_0000_0000, N=1, V=1; 0x8000_0000_0000_0000 - 1 -> V=1, C=1.
REQ-036 8 back-to-back random ops, out_ready low for 3 cycles mid-stream -> in_ready low during the stall, all 8 results in order, matching a reference model, none dropped or repeated.
REQ-037 reset pulsed for 1 cycle with 3 ops in flight -> out_valid=0 the following cycle, no stale result ever emerges, and the next op returns correctly after 4 cycles.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// Shared types for the sliced pipelined adder: the ARM-style flag word and its bit positions.
package pipe_adder_pkg;

  localparam int FLAGS_W = 4;
  localparam int FLAG_V  = 0;
  localparam int FLAG_C  = 1;
  localparam int FLAG_Z  = 2;
  localparam int FLAG_N  = 3;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  function automatic flags_t arm_flags(input logic n, input logic z, input logic c, input logic v);
    flags_t f;
    f.n = n;
    f.z = z;
    f.c = c;
    f.v = v;
    return f;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit adder slice; also reports the carry into its top bit so the
// final slice can derive signed overflow.
module adder_slice
  import pipe_adder_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         msb_cin_o
);

  logic [W:0] total;

  assign total  = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
  assign sum_o  = total[W-1:0];
  assign cout_o = total[W];
  // Carry into the MSB falls out of the MSB's own sum bit: s = a ^ b ^ cin.
  assign msb_cin_o = sum_o[W-1] ^ a_i[W-1] ^ b_i[W-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract: one SLICE-wide addition per stage, carry and not-yet-consumed
// operand bits travel forward; the last stage registers sum together with {N,Z,C,V}.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [3:0]       flags
);

  localparam int SAFE_STAGES = (STAGES < 1) ? 1 : STAGES;
  localparam int SLICE       = WIDTH / SAFE_STAGES;
  localparam int LAST        = SAFE_STAGES - 1;

  if ((STAGES < 1) || ((WIDTH % SAFE_STAGES) != 0)) begin : g_param_check
    $error("pipe_adder: STAGES must be >= 1 and divide WIDTH");
  end

  logic adv;

  // The whole pipe moves as one: it stalls only when a finished result is not taken.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar gi = 0; gi < SAFE_STAGES; gi++) begin : g_stage
    localparam int LO = gi * SLICE;
    localparam int BW = WIDTH - LO;
    // Mid stages carry {cout, upper b_eff, word}; the last holds {flags, sum}.
    localparam int DW = (gi == LAST) ? WIDTH + FLAGS_W : WIDTH + BW - SLICE + 1;

    logic             valid_in;
    logic             cin;
    logic [WIDTH-1:0] word_in;
    logic [BW-1:0]    b_in;
    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_msb_cin;
    logic [WIDTH-1:0] word_d;
    logic [DW-1:0]    data_d;
    logic [DW-1:0]    data_q;
    logic             valid_q;

    // "word" holds finished sum slices below LO and still-unconsumed a bits above.
    if (gi == 0) begin : g_first
      assign valid_in = in_valid;
      assign cin      = sub;
      assign word_in  = a;
      assign b_in     = sub ? ~b : b;
    end else begin : g_next
      assign valid_in = g_stage[gi-1].valid_q;
      assign word_in  = g_stage[gi-1].data_q[WIDTH-1:0];
      assign b_in     = g_stage[gi-1].data_q[WIDTH+BW-1:WIDTH];
      assign cin      = g_stage[gi-1].data_q[WIDTH+BW];
    end

    adder_slice #(
      .W(SLICE)
    ) u_slice (
      .a_i      (word_in[LO +: SLICE]),
      .b_i      (b_in[SLICE-1:0]),
      .cin_i    (cin),
      .sum_o    (slice_sum),
      .cout_o   (slice_cout),
      .msb_cin_o(slice_msb_cin)
    );

    always_comb begin
      word_d              = word_in;
      word_d[LO +: SLICE] = slice_sum;
    end

    if (gi == LAST) begin : g_last
      flags_t flags_d;

      assign flags_d = arm_flags(word_d[WIDTH-1], (word_d == '0), slice_cout,
                                 slice_msb_cin ^ slice_cout);
      assign data_d  = {flags_d, word_d};
    end else begin : g_mid
      logic msb_cin_unused;

      assign msb_cin_unused = slice_msb_cin;
      assign data_d         = {slice_cout, b_in[BW-1:SLICE], word_d};
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (adv) begin
        valid_q <= valid_in;
        data_q  <= data_d;
      end
    end
  end

  flags_t last_flags;

  assign last_flags    = g_stage[LAST].data_q[WIDTH +: FLAGS_W];
  assign out_valid     = g_stage[LAST].valid_q;
  assign sum           = g_stage[LAST].data_q[WIDTH-1:0];
  assign flags[FLAG_N] = last_flags.n;
  assign flags[FLAG_Z] = last_flags.z;
  assign flags[FLAG_C] = last_flags.c;
  assign flags[FLAG_V] = last_flags.v;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: directed corner cases, a stall, a mid-flight reset
// and a randomized phase, all scored against a plain-arithmetic reference model.
module tb_pipe_adder;
  import pipe_adder_pkg::*;

  localparam int WIDTH  = 64;
  localparam int STAGES = 4;
  localparam int CW     = WIDTH + 4;
  typedef logic [CW-1:0] cmp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic [3:0]       flags;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   n_out        = 0;
  cmp_t exp_q[$];
  cmp_t exp_v;

  always #5 clk = ~clk;

  pipe_adder #(
    .WIDTH (WIDTH),
    .STAGES(STAGES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .flags    (flags)
  );

  task automatic check_eq(input string tag, input cmp_t got, input cmp_t exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain wide arithmetic, result packed as {sum, N, Z, C, V}.
  function automatic cmp_t ref_model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                     input logic sv);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] be;
    logic [WIDTH-1:0] r;
    logic             n, z, c, v;
    be   = sv ? ~bv : bv;
    full = {1'b0, av} + {1'b0, be} + (WIDTH + 1)'(sv);
    r    = full[WIDTH-1:0];
    n    = r[WIDTH-1];
    z    = (r == '0);
    c    = full[WIDTH];
    v    = (av[WIDTH-1] == be[WIDTH-1]) && (r[WIDTH-1] != av[WIDTH-1]);
    return {r, n, z, c, v};
  endfunction

  function automatic logic [WIDTH-1:0] rnd64();
    case ($urandom_range(0, 7))
      0:       return 64'hFFFF_FFFF_FFFF_FFFF;
      1:       return 64'h0;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Scoreboard: pop on every consumed result, push on every accepted operation.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      check_eq("in_ready", cmp_t'(in_ready), cmp_t'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("no_pending_result", cmp_t'(out_valid), cmp_t'(0));
        end else begin
          exp_v = exp_q.pop_front();
          check_eq("result", {sum, flags}, exp_v);
          n_out++;
          $display("[TB] result %0d sum=%h flags=%b", n_out, sum, flags);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_model(a, b, sub));
    end
  end

  task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic sv);
    int n;
    n        = 0;
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    sub      = sv;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("accept_timeout", cmp_t'(in_ready), cmp_t'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] bv, input logic sv,
                          input logic [WIDTH-1:0] es, input logic [3:0] ef);
    int lat;
    send(av, bv, sv);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_eq({tag, "_latency"}, cmp_t'(lat), cmp_t'(STAGES));
    check_eq({tag, "_value"}, {sum, flags}, {es, ef});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain_empty", cmp_t'(exp_q.size()), cmp_t'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic acc;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("reset_out_valid", cmp_t'(out_valid), cmp_t'(0));
    check_eq("reset_sum_flags", {sum, flags}, cmp_t'(0));
    check_eq("reset_in_ready", cmp_t'(in_ready), cmp_t'(1));
    @(posedge clk);
    #1;

    directed("add_5_3", 64'd5, 64'd3, 1'b0, 64'd8, 4'b0000);
    directed("carry_all", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 4'b0110);
    directed("sub_3_5", 64'd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);
    directed("sub_5_5", 64'd5, 64'd5, 1'b1, 64'd0, 4'b0110);
    directed("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b1001);
    directed("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011);

    // Eight back-to-back ops with a three-cycle consumer stall once results are flowing.
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) send(rnd64(), rnd64(), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check_eq("stall_in_ready", cmp_t'(in_ready), cmp_t'(0));
          check_eq("stall_out_valid", cmp_t'(out_valid), cmp_t'(1));
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check_eq("stall_count", cmp_t'(n_out - n0), cmp_t'(8));

    // Reset with three operations in flight, plus one offered during the reset cycle.
    for (int i = 0; i < 3; i++) send(rnd64(), rnd64(), 1'b0);
    reset    = 1'b1;
    in_valid = 1'b1;
    a        = 64'd1;
    b        = 64'd1;
    sub      = 1'b0;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", cmp_t'(out_valid), cmp_t'(0));
    check_eq("rst_in_ready", cmp_t'(in_ready), cmp_t'(1));
    check_eq("rst_sum_flags", {sum, flags}, cmp_t'(0));
    repeat (8) begin
      @(negedge clk);
      check_eq("rst_no_stale", cmp_t'(out_valid), cmp_t'(0));
    end
    @(posedge clk);
    #1;
    directed("post_reset", 64'd9, 64'd4, 1'b0, 64'd13, 4'b0000);

    // Randomized traffic with random bubbles and random back-pressure.
    n0 = n_out;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a        = rnd64();
        b        = rnd64();
        sub      = 1'($urandom_range(0, 1));
      end
    end
    in_valid = 1'b0;
    drain();
    check_eq("random_progress", cmp_t'(n_out - n0 > 50), cmp_t'(1));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
